// File: rtl/led_activity_monitor.sv
// ---------------------------------------------------------------------------
// led_activity_monitor
//
// Clock-activity indicator. A free-running counter, advanced by a prescaled
// tick, drives a small bank of LEDs in one of four display modes. A 4-phase
// snapshot handshake lets another agent capture the counter value.
//
// Parameters
//   CNT_WIDTH  activity counter width (>= NUM_LEDS+1)
//   NUM_LEDS   number of LED outputs (>= 1)
//   PRESCALE   enabled clk cycles per count tick (>= 1)
//   ACTIVE_LOW 1 = LED outputs inverted (on = 0)
//
// Ports
//   clk        monitored clock, sole clock domain
//   reset      synchronous active-high reset (highest priority)
//   en         count enable; low holds prescaler, counter and walk pattern
//   clear      synchronous clear of counter, prescaler, walk and wrap
//   mode       LED display mode: 0 counter MSBs, 1 heartbeat, 2 walk,
//              3 snapshot MSBs
//   snap_req   snapshot request (4-phase handshake)
//   snap_valid snapshot valid / acknowledge
//   snap_count captured counter value
//   wrap       one-cycle pulse after the counter wraps all-ones -> 0
//   led        registered LED drive
// ---------------------------------------------------------------------------
module led_activity_monitor #(
  parameter int CNT_WIDTH  = 30,
  parameter int NUM_LEDS   = 4,
  parameter int PRESCALE   = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clear,
  input  logic [1:0]           mode,
  input  logic                 snap_req,
  output logic                 snap_valid,
  output logic [CNT_WIDTH-1:0] snap_count,
  output logic                 wrap,
  output logic [NUM_LEDS-1:0]  led
);

  // Prescaler width; PRESCALE=1 still gets a 1-bit register that stays 0.
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  // Width of the counter field below the LED-visible MSBs.
  localparam int LOW_W = CNT_WIDTH - NUM_LEDS;

  localparam logic [NUM_LEDS-1:0] WALK_INIT = NUM_LEDS'(1);
  localparam logic [NUM_LEDS-1:0] LED_OFF   = {NUM_LEDS{ACTIVE_LOW != 0}};

  // -------------------------------------------------------------------------
  // Prescaler and activity counter
  // -------------------------------------------------------------------------
  logic [PRE_W-1:0]     pre_cnt;
  logic [PRE_W-1:0]     pre_cnt_nxt;
  logic                 tick;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] count_nxt;
  logic                 count_max;
  logic                 sub_roll;

  always_comb begin
    tick = en && (pre_cnt == PRE_LAST);
  end

  always_comb begin
    pre_cnt_nxt = pre_cnt;
    if (en) begin
      if (tick) begin
        pre_cnt_nxt = '0;
      end else begin
        pre_cnt_nxt = pre_cnt + PRE_W'(1);
      end
    end
  end

  always_comb begin
    count_nxt = count;
    if (tick) begin
      count_nxt = count + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    count_max = &count;
    // Rollover of the field just below the displayed MSBs: the walking
    // pattern advances once per change of the top NUM_LEDS bits.
    sub_roll  = tick && (&count[LOW_W-1:0]);
  end

  // -------------------------------------------------------------------------
  // Walking one-hot pattern
  // -------------------------------------------------------------------------
  logic [NUM_LEDS-1:0] walk;
  logic [NUM_LEDS-1:0] walk_rot;

  generate
    if (NUM_LEDS == 1) begin : g_walk_single
      always_comb begin
        walk_rot = walk;
      end
    end else begin : g_walk_multi
      always_comb begin
        walk_rot = {walk[NUM_LEDS-2:0], walk[NUM_LEDS-1]};
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Counter-side state: prescaler, count, walk, wrap
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
      count   <= '0;
      walk    <= WALK_INIT;
      wrap    <= 1'b0;
    end else if (clear) begin
      pre_cnt <= '0;
      count   <= '0;
      walk    <= WALK_INIT;
      wrap    <= 1'b0;
    end else begin
      pre_cnt <= pre_cnt_nxt;
      count   <= count_nxt;
      if (sub_roll) begin
        walk <= walk_rot;
      end
      // Registered so the pulse lands in the cycle where count reads 0.
      wrap    <= tick && count_max;
    end
  end

  // -------------------------------------------------------------------------
  // Snapshot handshake FSM
  // -------------------------------------------------------------------------
  typedef enum logic {
    SNAP_IDLE,
    SNAP_HELD
  } snap_state_t;

  snap_state_t snap_state;
  snap_state_t snap_state_nxt;
  logic        capture;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_state <= SNAP_IDLE;
    end else begin
      snap_state <= snap_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    snap_state_nxt = snap_state;
    unique case (snap_state)
      SNAP_IDLE: begin
        if (snap_req) begin
          snap_state_nxt = SNAP_HELD;
        end
      end
      SNAP_HELD: begin
        if (!snap_req) begin
          snap_state_nxt = SNAP_IDLE;
        end
      end
      default: snap_state_nxt = SNAP_IDLE;
    endcase
  end

  // Output logic: snap_valid is the HELD state bit, so it is registered.
  always_comb begin
    snap_valid = (snap_state == SNAP_HELD);
    capture    = (snap_state == SNAP_IDLE) && snap_req;
  end

  // Capture samples the pre-update count, so a capture coinciding with a
  // tick or clear records the value visible in that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_count <= '0;
    end else if (capture) begin
      snap_count <= count;
    end
  end

  // -------------------------------------------------------------------------
  // LED display
  // -------------------------------------------------------------------------
  logic [NUM_LEDS-1:0] led_raw;
  logic [NUM_LEDS-1:0] led_nxt;

  always_comb begin
    led_raw = '0;
    unique case (mode)
      2'd0:    led_raw = count[CNT_WIDTH-1 -: NUM_LEDS];
      2'd1:    led_raw = {NUM_LEDS{count[CNT_WIDTH-1]}};
      2'd2:    led_raw = walk;
      2'd3:    led_raw = snap_count[CNT_WIDTH-1 -: NUM_LEDS];
      default: led_raw = '0;
    endcase
  end

  always_comb begin
    led_nxt = (ACTIVE_LOW != 0) ? ~led_raw : led_raw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led <= LED_OFF;
    end else begin
      led <= led_nxt;
    end
  end

endmodule
